aes_mixcol_seq: RTL and testbench
=================================

// Module: aes_mixcol_seq
// PURPOSE
//  Iterative AES MixColumns / InvMixColumns engine for one full 128-bit state.
//  Sequences one or more shared byte-mixer units over all 16 state bytes.
//  Sits between the SubBytes/ShiftRows stage and AddRoundKey in the round loop.
//  Valid/ready on both sides; one state in flight at a time.
// PARAMETERS
//  LANES  1  byte-mixer instances used per cycle; legal values are 1, 2 and 4.
//            Sets N = 16/LANES compute cycles per state.
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  in_valid   in   1    in_data/in_mode are valid
//  in_ready   out  1    engine can accept a state this cycle
//  in_data    in   128  state; byte s(r,c) = in_data[127-32c-8r -: 8]
//  in_mode    in   1    0 = MixColumns (fwd), 1 = InvMixColumns (inv)
//  out_valid  out  1    out_data holds the result
//  out_ready  in   1    consumer accepts out_data
//  out_data   out  128  result, same byte mapping as in_data
//  busy       out  1    high in RUN or DONE
// BEHAVIOUR
//  - Reset (async, rst_n=0): FSM=IDLE, cnt=0, out_valid=0, out_data=0, busy=0,
//    in_ready=0 while rst_n=0. Reset mid-operation discards the state in flight.
//  - FSM states: IDLE -> RUN -> DONE -> IDLE.
//    IDLE: in_ready=1. in_valid&in_ready: capture in_data into src_q and in_mode
//      into mode_q, cnt=0, go to RUN.
//    RUN: each cycle compute LANES bytes with index k=cnt..cnt+LANES-1
//      (col=k[3:2], row=k[1:0]). Write each result into dst_q, then cnt+=LANES.
//      On the cycle that writes k=15, go to DONE.
//    DONE: out_valid=1, out_data=dst_q, held stable until out_ready.
//  - Latency: out_valid rises exactly N clocks after the accepting edge.
//  - Back-to-back: in_ready = IDLE | (DONE & out_ready). An accept in DONE goes
//    straight to RUN with no IDLE bubble.
//  - Mixer operands for byte (r,c): a=s(r,c), b=s(r+1,c), c=s(r+2,c), d=s(r+3,c),
//    with the row index mod 4. The mixer gives fwd = 2a^3b^c^d and
//    inv = 14a^11b^13c^9d in GF(2^8), with x^8+x^4+x^3+x+1.
//    mode_q selects which of fwd/inv is written.
//  - Inputs are sampled only on an accept. in_valid/in_mode/in_data changes
//    during RUN/DONE are ignored.
//  - cnt is 4 bits. It wraps 15->0 only at completion, never mid-state.
//  - out_ready while not in DONE: no effect.
//  - out_data keeps its last result after the handshake, until the next DONE
//    overwrites it.
// CONFIGURATION
//  AES_MIXCOL_INV_EN defined: in_mode is honoured and both fwd and inv are
//    available.
//  Not defined: in_mode is ignored, mode_q is tied to 0 and only fwd is ever
//    written. The inv datapath is not instantiated or is optimised away.
//    Port list is unchanged.
// STRUCTURE
//  - Package aes_mixcol_pkg:
//    - FSM state encoding (IDLE/RUN/DONE).
//    - NUM_BYTES=16 and MODE_FWD=0 / MODE_INV=1.
//    - Byte-index helper functions: col/row from k, row rotate mod 4.
//  - Sub-module mixcol_byte_unit: combinational (a,b,c,d) -> (fwd, inv).
//    Instantiated LANES times inside a generate loop.
//  - Top level: FSM, cnt, src_q/dst_q registers and the operand-select muxes.
// TESTING
//  1) FIPS-197 fwd, LANES=1: in_data=db135345_f20a225c_01010101_c6c6c6c6, mode 0
//     -> out_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid 16 clks after
//     accept.
//  2) Inv round-trip: in=8e4da1bc_9fdc589d_01010101_c6c6c6c6, mode 1
//     -> db135345_f20a225c_01010101_c6c6c6c6. Without AES_MIXCOL_INV_EN the same
//     stimulus gives the fwd result.
//  3) Back-to-back with out_ready tied 1: two states
//     d4d4d4d5_2d26314c_..., then 01010101_...
//     -> second accept on the DONE cycle, results d5d5d7d6_4d7ebdf8_... in order,
//     no bubble.
//  4) Output stall: hold out_ready=0 for 5 clks in DONE
//     -> out_data stable, in_ready=0, a new in_valid is not accepted.
//     Release -> one handshake.
//  5) Reset mid-RUN: assert rst_n=0 at cnt=7
//     -> out_valid=0, out_data=0, busy=0 at once. Next state processes
//     correctly from cnt=0.
//  6) LANES=2 and LANES=4: repeat scenario 1
//     -> identical out_data, out_valid after 8 and 4 clks.

Source files
------------

// File: rtl/aes_mixcol_pkg.sv
// Shared constants, FSM encoding and byte/GF(2^8) helpers for the iterative
// AES MixColumns engine (inverse path enabled by AES_MIXCOL_INV_EN).
package aes_mixcol_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam int   NUM_BYTES = 16;
    localparam logic MODE_FWD  = 1'b0;
    localparam logic MODE_INV  = 1'b1;

    // Byte index k = 4*col + row, matching the column-major state layout.
    function automatic logic [1:0] k_col(input logic [3:0] k);
        return k[3:2];
    endfunction

    function automatic logic [1:0] k_row(input logic [3:0] k);
        return k[1:0];
    endfunction

    function automatic logic [1:0] row_rot(input logic [1:0] row, input logic [1:0] n);
        return row + n;
    endfunction

    // Byte k lives at bit offset 8*(15-k), and 15-k is ~k in four bits.
    function automatic logic [7:0] get_byte(input logic [127:0] s, input logic [3:0] k);
        return s[{~k, 3'b000} +: 8];
    endfunction

    function automatic logic [127:0] set_byte(input logic [127:0] s, input logic [3:0] k,
                                              input logic [7:0] v);
        logic [127:0] r;
        r = s;
        r[{~k, 3'b000} +: 8] = v;
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/mixcol_byte_unit.sv
// Combinational single-byte MixColumns mixer: fwd = 2a^3b^c^d, and with
// AES_MIXCOL_INV_EN also inv = 14a^11b^13c^9d (otherwise inv is tied to zero).
module mixcol_byte_unit
    import aes_mixcol_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] c,
    input  logic [7:0] d,
    output logic [7:0] fwd,
    output logic [7:0] inv
);

    assign fwd = xtime(a) ^ xtime(b) ^ b ^ c ^ d;

`ifdef AES_MIXCOL_INV_EN
    logic [7:0] a2_s, a4_s, a8_s, b2_s, b4_s, b8_s;
    logic [7:0] c2_s, c4_s, c8_s, d2_s, d4_s, d8_s;

    assign a2_s = xtime(a);
    assign a4_s = xtime(a2_s);
    assign a8_s = xtime(a4_s);
    assign b2_s = xtime(b);
    assign b4_s = xtime(b2_s);
    assign b8_s = xtime(b4_s);
    assign c2_s = xtime(c);
    assign c4_s = xtime(c2_s);
    assign c8_s = xtime(c4_s);
    assign d2_s = xtime(d);
    assign d4_s = xtime(d2_s);
    assign d8_s = xtime(d4_s);

    // 14 = 8+4+2, 11 = 8+2+1, 13 = 8+4+1, 9 = 8+1
    assign inv = (a8_s ^ a4_s ^ a2_s) ^ (b8_s ^ b2_s ^ b) ^
                 (c8_s ^ c4_s ^ c) ^ (d8_s ^ d);
`else
    assign inv = 8'h00;
`endif

endmodule

// File: rtl/aes_mixcol_seq.sv
// Iterative AES MixColumns/InvMixColumns engine over one 128-bit state,
// LANES bytes per cycle. AES_MIXCOL_INV_EN enables the in_mode inverse path.
module aes_mixcol_seq
    import aes_mixcol_pkg::*;
#(
    parameter int LANES = 1
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam logic [3:0] LAST_CNT = 4'(NUM_BYTES - LANES);
    localparam logic [3:0] CNT_STEP = 4'(LANES);

    state_t         state_r;
    logic [3:0]     cnt_r;
    logic [127:0]   src_r;
    logic [127:0]   dst_r;
    logic [127:0]   dst_next_s;
    logic [127:0]   out_data_r;
    logic           out_valid_r;
    logic           mode_sel_s;
    logic           accept_s;
    logic [3:0]     lane_k_s   [LANES];
    logic [7:0]     lane_res_s [LANES];

    assign in_ready  = rst_n & ((state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready));
    assign accept_s  = in_valid & in_ready;
    assign busy      = (state_r == ST_RUN) | (state_r == ST_DONE);
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

`ifdef AES_MIXCOL_INV_EN
    logic mode_r;

    // Mode latch, loaded only on an accepted state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r <= MODE_FWD;
        end else if (accept_s) begin
            mode_r <= in_mode;
        end
    end

    assign mode_sel_s = mode_r;
`else
    logic unused_mode_s;

    assign unused_mode_s = in_mode;
    assign mode_sel_s    = MODE_FWD;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [3:0] k_s;
        logic [1:0] col_s;
        logic [1:0] row_s;
        logic [7:0] fwd_s;
        logic [7:0] inv_s;

        assign k_s   = cnt_r + 4'(g);
        assign col_s = k_col(k_s);
        assign row_s = k_row(k_s);

        mixcol_byte_unit u_unit (
            .a   (get_byte(src_r, {col_s, row_s})),
            .b   (get_byte(src_r, {col_s, row_rot(row_s, 2'd1)})),
            .c   (get_byte(src_r, {col_s, row_rot(row_s, 2'd2)})),
            .d   (get_byte(src_r, {col_s, row_rot(row_s, 2'd3)})),
            .fwd (fwd_s),
            .inv (inv_s)
        );

        assign lane_k_s[g]   = k_s;
        assign lane_res_s[g] = (mode_sel_s == MODE_INV) ? inv_s : fwd_s;
    end

    // Merge this cycle's lane results into the destination state.
    always_comb begin
        dst_next_s = dst_r;
        for (int i = 0; i < LANES; i++) begin
            dst_next_s = set_byte(dst_next_s, lane_k_s[i], lane_res_s[i]);
        end
    end

    // Control FSM and state registers; out_data is a separate register so it
    // survives the handshake while the next state is being computed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            src_r       <= 128'd0;
            dst_r       <= 128'd0;
            out_data_r  <= 128'd0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        src_r   <= in_data;
                        cnt_r   <= 4'd0;
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    dst_r <= dst_next_s;
                    if (cnt_r == LAST_CNT) begin
                        cnt_r       <= 4'd0;
                        out_data_r  <= dst_next_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_STEP;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        if (accept_s) begin
                            src_r   <= in_data;
                            cnt_r   <= 4'd0;
                            state_r <= ST_RUN;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= 4'd0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_mixcol_seq.sv
// Directed self-checking bench for aes_mixcol_seq (LANES=1 main instance,
// plus LANES=2 and LANES=4 instances for the latency/lane-count scenario).
module tb_aes_mixcol_seq;

    localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2_IN  = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
    localparam logic [127:0] V2_OUT = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;
    localparam logic [127:0] V3_IN  = 128'h01010101_c6c6c6c6_db135345_f20a225c;
    localparam logic [127:0] V3_OUT = 128'h01010101_c6c6c6c6_8e4da1bc_9fdc589d;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic         in_valid_m;
    logic         out_ready_m;
    logic         in_ready2, out_valid2, busy2;
    logic         in_ready4, out_valid4, busy4;
    logic [127:0] out_data2, out_data4;

    int total;
    int bad;

    aes_mixcol_seq #(.LANES(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    aes_mixcol_seq #(.LANES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_m), .in_ready(in_ready2),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid2),
        .out_ready(out_ready_m), .out_data(out_data2), .busy(busy2)
    );

    aes_mixcol_seq #(.LANES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_m), .in_ready(in_ready4),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid4),
        .out_ready(out_ready_m), .out_data(out_data4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one accepted state; caller sits 1 time unit after a rising edge.
    task automatic send(input logic [127:0] data, input logic mode);
        in_data  = data;
        in_mode  = mode;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count rising edges until out_valid, bounded.
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 128'd0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_fwd;
        int cyc;
        send(V1_IN, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL fwd_busy_run got=%b exp=1", busy); end
        wait_out(cyc);
        total++; if (cyc != 16) begin bad++; $display("FAIL fwd_latency got=%0d exp=16", cyc); end
        total++; if (out_data !== V1_OUT) begin bad++; $display("FAIL fwd_data got=%h exp=%h", out_data, V1_OUT); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fwd_done_in_ready got=%b exp=0", in_ready); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fwd_hs_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fwd_hs_busy got=%b exp=0", busy); end
        total++; if (out_data !== V1_OUT) begin bad++; $display("FAIL fwd_hold_data got=%h exp=%h", out_data, V1_OUT); end
    endtask

    task automatic test_inv;
        int cyc;
`ifdef AES_MIXCOL_INV_EN
        send(V1_OUT, 1'b1);
        wait_out(cyc);
        total++; if (out_data !== V1_IN) begin bad++; $display("FAIL inv_data got=%h exp=%h", out_data, V1_IN); end
`else
        send(V1_IN, 1'b1);
        wait_out(cyc);
        total++; if (out_data !== V1_OUT) begin bad++; $display("FAIL inv_ignored_data got=%h exp=%h", out_data, V1_OUT); end
`endif
        total++; if (cyc != 16) begin bad++; $display("FAIL inv_latency got=%0d exp=16", cyc); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int cyc;
        out_ready = 1'b1;
        send(V2_IN, 1'b0);
        wait_out(cyc);
        total++; if (cyc != 16) begin bad++; $display("FAIL b2b_lat_a got=%0d exp=16", cyc); end
        total++; if (out_data !== V2_OUT) begin bad++; $display("FAIL b2b_data_a got=%h exp=%h", out_data, V2_OUT); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_done_ready got=%b exp=1", in_ready); end
        send(V3_IN, 1'b0);
        total++; if (out_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL b2b_no_bubble got=%b%b exp=01", out_valid, busy); end
        wait_out(cyc);
        total++; if (cyc != 16) begin bad++; $display("FAIL b2b_lat_b got=%0d exp=16", cyc); end
        total++; if (out_data !== V3_OUT) begin bad++; $display("FAIL b2b_data_b got=%h exp=%h", out_data, V3_OUT); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b%b exp=00", out_valid, busy); end
        total++; if (out_data !== V3_OUT) begin bad++; $display("FAIL b2b_hold got=%h exp=%h", out_data, V3_OUT); end
    endtask

    task automatic test_stall;
        int cyc;
        send(V1_IN, 1'b0);
        wait_out(cyc);
        in_data  = V2_IN;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || out_data !== V1_OUT) begin bad++; $display("FAIL stall_hold%0d got=%b/%h exp=1/%h", i, out_valid, out_data, V1_OUT); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready%0d got=%b exp=0", i, in_ready); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_release got=%b exp=0", out_valid); end
        @(posedge clk); #1;
        total++; if (busy !== 1'b0 || out_data !== V1_OUT) begin bad++; $display("FAIL stall_no_accept got=%b/%h exp=0/%h", busy, out_data, V1_OUT); end
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        send(V2_IN, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_run_ctl got=%b%b exp=00", out_valid, busy); end
        total++; if (out_data !== 128'd0) begin bad++; $display("FAIL rst_run_data got=%h exp=0", out_data); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        send(V3_IN, 1'b0);
        wait_out(cyc);
        total++; if (cyc != 16) begin bad++; $display("FAIL rst_after_lat got=%0d exp=16", cyc); end
        total++; if (out_data !== V3_OUT) begin bad++; $display("FAIL rst_after_data got=%h exp=%h", out_data, V3_OUT); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_lanes;
        int c2, c4;
        logic [127:0] d2, d4;
        c2 = -1; c4 = -1; d2 = 128'd0; d4 = 128'd0;
        out_ready_m = 1'b1;
        in_data     = V1_IN;
        in_mode     = 1'b0;
        in_valid_m  = 1'b1;
        @(posedge clk); #1;
        in_valid_m  = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            @(posedge clk); #1;
            if (out_valid2 === 1'b1 && c2 < 0) begin c2 = i; d2 = out_data2; end
            if (out_valid4 === 1'b1 && c4 < 0) begin c4 = i; d4 = out_data4; end
        end
        total++; if (c2 != 8) begin bad++; $display("FAIL lanes2_latency got=%0d exp=8", c2); end
        total++; if (d2 !== V1_OUT) begin bad++; $display("FAIL lanes2_data got=%h exp=%h", d2, V1_OUT); end
        total++; if (c4 != 4) begin bad++; $display("FAIL lanes4_latency got=%0d exp=4", c4); end
        total++; if (d4 !== V1_OUT) begin bad++; $display("FAIL lanes4_data got=%h exp=%h", d4, V1_OUT); end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        in_valid    = 1'b0;
        in_data     = 128'd0;
        in_mode     = 1'b0;
        out_ready   = 1'b0;
        in_valid_m  = 1'b0;
        out_ready_m = 1'b0;
        test_reset();
        test_fwd();
        test_inv();
        test_back_to_back();
        test_stall();
        test_reset_mid_run();
        test_lanes();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
